// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple of A+B+Cin over WIDTH cycles, result registered on completion.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t         state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] addend;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sbit_c;
   logic             carry_next_c;

   // One full-adder slice on the current LSBs
   always_comb begin
      sbit_c       = acc[0] ^ addend[0] ^ carry;
      carry_next_c = (acc[0] & addend[0]) | (acc[0] & carry) | (addend[0] & carry);
   end

   // acc holds the augend and fills from the MSB with sum bits, so after WIDTH shifts it is the result
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         addend <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Sum    <= '0;
         Cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         Ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  acc    <= A;
                  addend <= B;
                  carry  <= Cin;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               acc    <= {sbit_c, acc[WIDTH-1:1]};
               addend <= addend >> 1;
               carry  <= carry_next_c;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  Sum   <= {sbit_c, acc[WIDTH-1:1]};
                  Cout  <= carry_next_c;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry into the MSB is the carry entering this final slice
                  Ovf   <= carry ^ carry_next_c;
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases plus random operations,
// expectations from plain integer arithmetic; Ovf checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks   = 0;
   int failures = 0;
   exp_t exp_q[$];
   logic [W-1:0] last_sum;
   logic         last_cout;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (a_in),
      .B     (b_in),
      .Cin   (cin_in),
      .busy  (busy),
      .done  (done),
      .Sum   (sum),
      .Cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .Ovf   (ovf)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      exp_t e;
      int unsigned total;
      int sa, sb, ss;
      total  = int'(a) + int'(b) + int'(c);
      e.sum  = W'(total % (1 << W));
      e.cout = (total >= (1 << W));
      sa = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
      sb = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
      ss = sa + sb + int'(c);
      e.ovf  = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e.sum));
            check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
      end
   end

   // Call at 1ns after an edge with the DUT in IDLE or DONE; returns 1ns after the DONE-entry
   // edge (or after abort). ign_k / rst_k inject an ignored start / reset in RUN cycle k (0 = none).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int ign_k, input int rst_k);
      exp_t e;
      e = model(a, b, c);
      start = 1'b1; a_in = a; b_in = b; cin_in = c;
      @(posedge clk); #1;
      start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
      if (rst_k == 0) exp_q.push_back(e);
      for (int k = 1; k <= int'(W); k++) begin
         if (k == rst_k) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_done", 32'(done), 32'(0));
            check("rst_sum", 32'(sum), 32'(0));
            check("rst_cout", 32'(cout), 32'(0));
            last_sum = '0; last_cout = 1'b0;
            for (int j = 0; j < int'(W) + 2; j++) begin
               @(posedge clk); #1;
               check("abort_no_done", 32'(done), 32'(0));
            end
            return;
         end
         check("run_busy", 32'(busy), 32'(1));
         check("run_done", 32'(done), 32'(0));
         check("hold_sum", 32'(sum), 32'(last_sum));
         check("hold_cout", 32'(cout), 32'(last_cout));
         if (k == ign_k) begin
            start = 1'b1; a_in = '1; b_in = '1; cin_in = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("end_busy", 32'(busy), 32'(0));
      check("end_done", 32'(done), 32'(1));
      last_sum = e.sum; last_cout = e.cout;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      check("idle_done", 32'(done), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
      last_sum = '0; last_cout = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_done", 32'(done), 32'(0));
      check("reset_sum", 32'(sum), 32'(0));
      check("reset_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
      check("reset_ovf", 32'(ovf), 32'(0));
`endif
      rst = 1'b0;
      idle_cycle();

      run_op(8'h0F, 8'h01, 1'b0, 0, 0); idle_cycle();
      run_op(8'hFF, 8'h01, 1'b0, 0, 0); idle_cycle();
      run_op(8'h00, 8'h00, 1'b1, 0, 0); idle_cycle();
      run_op(8'h7F, 8'h01, 1'b0, 0, 0); idle_cycle();
      run_op(8'h12, 8'h34, 1'b0, 3, 0); idle_cycle();
      run_op(8'hAA, 8'h55, 1'b0, 0, 4);
      run_op(8'h12, 8'h34, 1'b0, 0, 0);
      run_op(8'h80, 8'h80, 1'b0, 0, 0); idle_cycle();

      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0, 0);
         if ($urandom_range(0, 1) == 0) idle_cycle();
      end
      idle_cycle();
      repeat (2) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
